// File: rtl/rom_rr_arbiter.sv
// Round-robin arbiter that shares one single-port ROM between requesters A and B.
// It issues one read per clock, returns the data with a valid pulse and checks the ROM address echo.
module rom_rr_arbiter #(
  parameter int DATA_WIDTH = 7,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  a_req,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  output logic                  a_ack,
  output logic                  a_valid,
  output logic [DATA_WIDTH-1:0] a_data,
  input  logic                  b_req,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  output logic                  b_ack,
  output logic                  b_valid,
  output logic [DATA_WIDTH-1:0] b_data,
  output logic                  rom_ena,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_data,
  input  logic [ADDR_WIDTH-1:0] rom_addr_echo,
  output logic                  err,
  output logic                  busy
);

  typedef enum logic {IDLE, RD} state_t;

  state_t state;
  logic   ptr_b;
  logic   owner_b;
  logic   a_pend, b_pend, issue, win_b;

  // A port whose ack is still high is presenting the request that was just issued.
  always_comb begin
    a_pend = a_req & ~a_ack;
    b_pend = b_req & ~b_ack;
    issue  = a_pend | b_pend;
    win_b  = b_pend & (~a_pend | ptr_b);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      ptr_b    <= 1'b0;
      owner_b  <= 1'b0;
      a_ack    <= 1'b0;
      b_ack    <= 1'b0;
      a_valid  <= 1'b0;
      b_valid  <= 1'b0;
      a_data   <= '0;
      b_data   <= '0;
      rom_ena  <= 1'b0;
      rom_addr <= '0;
      err      <= 1'b0;
      busy     <= 1'b0;
    end else begin
      a_valid <= 1'b0;
      b_valid <= 1'b0;

      // Read completion: capture for the owner and compare the echoed address.
      if (state == RD) begin
        if (owner_b) begin
          b_data  <= rom_data;
          b_valid <= 1'b1;
        end else begin
          a_data  <= rom_data;
          a_valid <= 1'b1;
        end
        if (rom_addr_echo != rom_addr) err <= 1'b1;
      end

      // Issue: identical in IDLE and RD, which gives back-to-back reads.
      if (issue) begin
        rom_addr <= win_b ? b_addr : a_addr;
        rom_ena  <= 1'b1;
        a_ack    <= ~win_b;
        b_ack    <= win_b;
        owner_b  <= win_b;
        ptr_b    <= ~win_b;
        state    <= RD;
        busy     <= 1'b1;
      end else begin
        rom_ena  <= 1'b0;
        a_ack    <= 1'b0;
        b_ack    <= 1'b0;
        state    <= IDLE;
        busy     <= 1'b0;
      end
    end
  end

endmodule

// File: doc/rom_rr_arbiter.md
Name: rom_rr_arbiter

Overview:
- Round-robin arbiter and read sequencer that shares one single-port ROM between two requesters, A and B.
- Accepts read requests, drives the ROM address and enable, and captures the ROM data one clock later. It returns the data to the winning requester with a one-cycle valid pulse.
- Checks the ROM's address echo against the address issued. It sits between the ROM and its consumers, and the consumers never drive the ROM directly.

Parameters:
- DATA_WIDTH, 7, width of a ROM word.
- ADDR_WIDTH, 4, width of a ROM address (depth 2**ADDR_WIDTH).

Ports:
- clk  in  1  system clock; every register in this block updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- a_req  in  1  requester A read request; level-held until a_ack.
- a_addr  in  ADDR_WIDTH  requester A address; stable while a_req=1.
- a_ack  out  1  one-cycle pulse: A's request was accepted and issued to the ROM.
- a_valid  out  1  one-cycle pulse: a_data holds A's read result.
- a_data  out  DATA_WIDTH  A's read data; holds its value between reads.
- b_req, b_addr, b_ack, b_valid, b_data: same as the A ports, for requester B.
- rom_ena  out  1  ROM enable.
- rom_addr  out  ADDR_WIDTH  ROM address.
- rom_data  in  DATA_WIDTH  ROM data output.
- rom_addr_echo  in  ADDR_WIDTH  ROM latched-address output.
- err  out  1  sticky echo-mismatch flag.
- busy  out  1  1 while a read is in flight (state RD).

Behaviour:
- Reset (asynchronous, active-low):
  - Outputs: a_ack, b_ack, a_valid, b_valid, rom_ena, err and busy = 0; a_data, b_data and rom_addr = 0.
  - Internals: state = IDLE; priority pointer = A; in-flight owner tag cleared.
- ROM timing contract:
  - The ROM samples rom_addr/rom_ena on the falling edge of clk.
  - rom_data and rom_addr_echo are valid from that falling edge until the next falling edge.
  - All outputs of this block are registered, so rom_addr/rom_ena are stable across the falling edge.
  - While rom_ena=0, rom_data and rom_addr_echo are undefined (X). The block never captures them and never compares them in that case.
- FSM, state IDLE:
  - Issue condition: at a rising edge, a_req or b_req = 1.
  - Winner selection: the sole requester if only one is asserted; if both are asserted, the port named by the priority pointer.
  - On issue: register rom_addr = winner's addr and rom_ena = 1; pulse winner's ack (high for the following cycle); set owner tag = winner; flip the pointer to the non-winner; go to RD.
  - With no request: rom_ena = 0, stay in IDLE.
- FSM, state RD, at the next rising edge:
  - Capture: owner's data <= rom_data; pulse owner's valid for one cycle.
  - Echo check: if rom_addr_echo != rom_addr, set err = 1. err stays set until reset.
  - Back-to-back: if a request is pending, it is issued in the same edge using the same arbitration rule (stay in RD, rom_ena stays 1). Otherwise drop rom_ena and go to IDLE.
- Latency and throughput:
  - Latency: request sampled at edge T -> ack high in cycle T..T+1 -> valid high in cycle T+1..T+2, with data captured at edge T+1.
  - Sustained throughput: one read per clock.
- Requester handshake rules:
  - A requester whose ack is pulsing must not be re-arbitrated with its old request. The arbiter ignores a port's req during its ack cycle.
  - A requester keeping req high after its ack cycle issues a new read.
- Fairness: with both requesters continuously asserting, grants strictly alternate A, B, A, B. No port waits more than one issue slot.
- Port independence: a_valid and b_valid are never high in the same cycle, and a_ack and b_ack are never high in the same cycle.
- Reset mid-read: the in-flight read is discarded and no valid pulse is produced. rom_ena drops asynchronously.
- Address wrap: any value 0..2**ADDR_WIDTH-1 is legal and there is no wrap logic. The arbiter does not modify addresses.

Test Plan:
- Reset: hold rst_n=0 with a_req=1 -> all outputs 0, no ack; release -> a_ack pulses on the first edge.
- Single read: A reads addr 4'h3 with ROM[3]=7'h55 -> a_ack next cycle; a_valid one cycle later with a_data=7'h55; rom_ena high for exactly one cycle; b_* stay 0.
- Contention: both held high, a_addr=1, b_addr=2 -> issue order A,B,A,B on consecutive cycles; rom_ena high continuously; valid pulses alternate; data matches ROM[1]/ROM[2].
- Pointer fairness: B alone reads once, then both assert -> A is granted first.
- Echo mismatch: force rom_addr_echo=rom_addr^1 during one RD cycle -> err=1 from the next cycle, held across further reads until rst_n.
- Reset mid-read: assert rst_n=0 while busy=1 -> no valid pulse; rom_ena=0 immediately; state IDLE after release.
